// File: rtl/dmem_uart_pkg.sv
// dmem_uart_pkg: shared types and constants for the memory-mapped UART TX.
//   - tx_state_t     : serializer FSM states
//   - OFS_*          : register word offsets (address[3:2])
//   - ST_*           : STATUS read-field bit positions
//   - frame constants: 8N1 line levels and data bit count
package dmem_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Word offsets within the 16-byte window; byte lanes address[1:0] are ignored.
    localparam logic [1:0] OFS_TXDATA = 2'd0;
    localparam logic [1:0] OFS_STATUS = 2'd1;
    localparam logic [1:0] OFS_CLKDIV = 2'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    localparam int       DATA_BITS = 8;
    localparam logic     START_BIT = 1'b0;
    localparam logic     STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  : write request/data (ignored when full unless popping too)
//   pop, rdata   : read request; rdata shows the head combinationally
//   full, empty  : status flags
//   count        : current number of entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rptr];
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: UART transmitter responding on the CPU_Core data-memory bus.
// Stores to TXDATA are queued and sent as 8N1 frames on tx; loads return
// STATUS / CLKDIV. The system muxes read_data in place of RAM when hit=1.
// Ports:
//   CLK, RSTn          : clock, synchronous active-low reset
//   MemWrite, MemRead  : store / load strobes
//   address            : byte address (window decoded on address[9:4])
//   write_data         : store data
//   read_data          : load data, 0 unless MemRead && hit
//   hit                : address falls inside the register window
//   tx                 : serial output, idle high, driven from a flop
module dmem_uart_tx
    import dmem_uart_pkg::*;
#(
    parameter logic [9:0]  BASE_ADDR    = 10'h3F0,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] CLKDIV_RESET = 16'd434
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    ofs;
    logic          wr_en, wr_tx;
    logic          push, pop;
    logic          full, empty;
    logic [CW-1:0] count;
    logic [7:0]    fifo_head;
    logic [31:0]   count32;
    logic [3:0]    cnt_disp;

    logic [15:0]   clkdiv;
    logic          overflow;

    tx_state_t     state;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;
    logic [15:0]   bit_cnt;
    logic [15:0]   bit_div;
    logic          tx_q;
    logic          bit_done;

    logic          unused_bits;
    assign unused_bits = ^{write_data[31:16], address[1:0]};

    assign hit   = (address[9:4] == BASE_ADDR[9:4]);
    assign ofs   = address[3:2];
    assign wr_en = MemWrite && hit;
    assign wr_tx = wr_en && (ofs == OFS_TXDATA);

    // Bit timer counts down from bit_div-1; a bit period ends at zero.
    assign bit_done = (bit_cnt == 16'd0);
    // Head leaves the FIFO when a new frame is launched, either from IDLE or
    // straight out of the last STOP cycle.
    assign pop  = !empty && ((state == IDLE) || (state == STOP && bit_done));
    assign push = wr_tx && (!full || pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RSTn),
        .push  (push),
        .wdata (write_data[7:0]),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Registers
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            clkdiv   <= CLKDIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_en && ofs == OFS_CLKDIV)
                clkdiv <= (write_data[15:0] == 16'd0) ? 16'd1 : write_data[15:0];
            if (wr_tx && full && !pop)
                overflow <= 1'b1;
            else if (wr_en && ofs == OFS_STATUS && write_data[ST_OVF])
                overflow <= 1'b0;
        end
    end

    // Serializer. bit_div freezes the divider for the whole frame so a CLKDIV
    // write only affects the next frame.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
            bit_div <= 16'd1;
            tx_q    <= STOP_BIT;
        end else begin
            case (state)
                IDLE: begin
                    tx_q <= STOP_BIT;
                    if (!empty) begin
                        shreg   <= fifo_head;
                        bit_div <= clkdiv;
                        bit_cnt <= clkdiv - 16'd1;
                        tx_q    <= START_BIT;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_cnt <= bit_div - 16'd1;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                        state   <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= bit_div - 16'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            tx_q  <= STOP_BIT;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_q    <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        if (!empty) begin
                            shreg   <= fifo_head;
                            bit_div <= clkdiv;
                            bit_cnt <= clkdiv - 16'd1;
                            tx_q    <= START_BIT;
                            state   <= START;
                        end else begin
                            state   <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx = tx_q;

    assign count32  = 32'(count);
    assign cnt_disp = (count32 > 32'd15) ? 4'hF : count32[3:0];

    always_comb begin
        read_data = 32'd0;
        if (MemRead && hit) begin
            case (ofs)
                OFS_STATUS: begin
                    read_data[ST_FULL]                   = full;
                    read_data[ST_EMPTY]                  = empty;
                    read_data[ST_BUSY]                   = (state != IDLE);
                    read_data[ST_OVF]                    = overflow;
                    read_data[ST_CNT_LSB+3:ST_CNT_LSB]   = cnt_disp;
                end
                OFS_CLKDIV: read_data[15:0] = clkdiv;
                default:    read_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_uart_tx.sv
module tb_dmem_uart_tx;

    localparam logic [9:0] A_TX  = 10'h3F0;
    localparam logic [9:0] A_ST  = 10'h3F4;
    localparam logic [9:0] A_DIV = 10'h3F8;
    localparam logic [9:0] A_RES = 10'h3FC;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        hit;
    logic        tx;

    int n_cmp = 0;
    int n_err = 0;

    // tx is sampled 1 time unit after every rising edge into cap[].
    logic cap [0:4095];
    int   cap_n = 0;
    int   cap_base = 0;

    dmem_uart_tx dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit        (hit),
        .tx         (tx)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        if (cap_n < 4096) begin
            cap[cap_n] = tx;
            cap_n++;
        end
    end

    // Line level of cycle k (0..10*d-1) within an 8N1 frame of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int d, input int k);
        int slot;
        slot = k / d;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic bus_read(input logic [9:0] a, output logic [31:0] d);
        @(negedge CLK);
        address = a;
        MemRead = 1'b1;
        #1 d = read_data;
        MemRead = 1'b0;
    endtask

    task automatic bus_write(input logic [9:0] a, input logic [31:0] d);
        @(negedge CLK);
        address    = a;
        write_data = d;
        MemWrite   = 1'b1;
        @(negedge CLK);
        MemWrite   = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        int bad;
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
        cap_base = cap_n;
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h want %h", d, 32'h2); end
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd434) begin n_err++; $display("FAIL reset_clkdiv: got %0d want 434", d); end
        bus_read(A_TX, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL txdata_reads_zero: got %h want 0", d); end
        bus_read(A_RES, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL reserved_reads_zero: got %h want 0", d); end
        @(negedge CLK);
        address = A_ST;
        #1;
        n_cmp++;
        if (hit !== 1'b1) begin n_err++; $display("FAIL hit_in_window: got %b want 1", hit); end
        n_cmp++;
        if (read_data !== 32'h0) begin n_err++; $display("FAIL read_without_memread: got %h want 0", read_data); end
        repeat (10) @(posedge CLK);
        #2;
        bad = 0;
        for (int i = 0; i < 14; i++) if (cap[cap_base+i] !== 1'b1) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL reset_tx_idle: %0d low/unknown samples, want 0", bad); end
    endtask

    task automatic test_clkdiv;
        logic [31:0] d;
        bus_write(A_DIV, 32'h0);
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd1) begin n_err++; $display("FAIL clkdiv_zero_as_one: got %0d want 1", d); end
        // Read and write together: read returns the pre-edge value.
        @(negedge CLK);
        address = A_DIV; write_data = 32'hFFFF_0004; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        n_cmp++;
        if (read_data !== 32'd1) begin n_err++; $display("FAIL rw_same_cycle_old: got %0d want 1", read_data); end
        @(negedge CLK);
        MemWrite = 1'b0; MemRead = 1'b0;
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd4) begin n_err++; $display("FAIL clkdiv_write4: got %h want 4", d); end
    endtask

    task automatic test_single_frame;
        logic [31:0] d;
        logic e, got, want;
        int bad;
        @(negedge CLK);
        address = A_TX; write_data = 32'h55; MemWrite = 1'b1;
        cap_base = cap_n;
        @(negedge CLK);
        MemWrite = 1'b0;
        repeat (8) @(negedge CLK);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h6) begin n_err++; $display("FAIL frame_busy: got %h want 6", d); end
        repeat (45) @(posedge CLK);
        #2;
        bad = -1; got = 1'b0; want = 1'b0;
        for (int i = 0; i < 55; i++) begin
            e = (i == 0 || i > 40) ? 1'b1 : frame_bit(8'h55, 4, i - 1);
            if (bad < 0 && cap[cap_base+i] !== e) begin bad = i; got = cap[cap_base+i]; want = e; end
        end
        n_cmp++;
        if (bad !== -1) begin n_err++; $display("FAIL frame_55: cycle %0d tx=%b want %b", bad, got, want); end
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_err++; $display("FAIL frame_done_idle: got %h want 2", d); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [7:0] b [3];
        logic e, got, want;
        int bad, j;
        b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
        bus_write(A_DIV, 32'd2);
        @(negedge CLK);
        cap_base = cap_n;
        address = A_TX; MemWrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            write_data = {24'h0, b[i]};
            @(negedge CLK);
        end
        MemWrite = 1'b0;
        address = A_ST; MemRead = 1'b1;
        #1 d = read_data;
        MemRead = 1'b0;
        n_cmp++;
        if (d !== 32'h24) begin n_err++; $display("FAIL b2b_count2: got %h want 24", d); end
        repeat (70) @(posedge CLK);
        #2;
        bad = -1; got = 1'b0; want = 1'b0;
        for (int i = 0; i < 66; i++) begin
            j = i - 1;
            e = (j < 0 || j >= 60) ? 1'b1 : frame_bit(b[j/20], 2, j % 20);
            if (bad < 0 && cap[cap_base+i] !== e) begin bad = i; got = cap[cap_base+i]; want = e; end
        end
        n_cmp++;
        if (bad !== -1) begin n_err++; $display("FAIL b2b_frames: cycle %0d tx=%b want %b", bad, got, want); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [7:0] b [9];
        logic e, got, want;
        int bad, j;
        b[0] = 8'h10;
        for (int i = 1; i < 9; i++) b[i] = 8'(8'h1F + i);
        bus_write(A_DIV, 32'd4);
        @(negedge CLK);
        cap_base = cap_n;
        address = A_TX; write_data = {24'h0, b[0]}; MemWrite = 1'b1;
        @(negedge CLK);
        MemWrite = 1'b0;
        @(negedge CLK);
        // 9 writes while busy: 8 fill the FIFO, the 9th (0x28) is dropped.
        MemWrite = 1'b1;
        for (int i = 0; i < 9; i++) begin
            write_data = 32'h20 + 32'(i);
            @(negedge CLK);
        end
        MemWrite = 1'b0;
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h8D) begin n_err++; $display("FAIL ovf_status: got %h want 8d", d); end
        bus_write(A_ST, 32'h8);
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h85) begin n_err++; $display("FAIL ovf_cleared: got %h want 85", d); end
        repeat (400) @(posedge CLK);
        #2;
        bad = -1; got = 1'b0; want = 1'b0;
        for (int i = 0; i < 402; i++) begin
            j = i - 1;
            e = (j < 0 || j >= 360) ? 1'b1 : frame_bit(b[j/40], 4, j % 40);
            if (bad < 0 && cap[cap_base+i] !== e) begin bad = i; got = cap[cap_base+i]; want = e; end
        end
        n_cmp++;
        if (bad !== -1) begin n_err++; $display("FAIL ovf_nine_frames: cycle %0d tx=%b want %b", bad, got, want); end
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_err++; $display("FAIL ovf_drained: got %h want 2", d); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] d;
        int bad;
        @(negedge CLK);
        address = A_TX; write_data = 32'h00; MemWrite = 1'b1;
        @(negedge CLK);
        write_data = 32'h5A;
        @(negedge CLK);
        MemWrite = 1'b0;
        repeat (16) @(negedge CLK);
        address = A_ST; MemRead = 1'b1;
        #1 d = read_data;
        MemRead = 1'b0;
        n_cmp++;
        if (d !== 32'h14) begin n_err++; $display("FAIL pre_reset_status: got %h want 14", d); end
        @(negedge CLK);
        n_cmp++;
        if (tx !== 1'b0) begin n_err++; $display("FAIL pre_reset_bit3: tx=%b want 0", tx); end
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin n_err++; $display("FAIL reset_abort_tx: tx=%b want 1", tx); end
        @(negedge CLK);
        RSTn = 1'b1;
        cap_base = cap_n;
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_err++; $display("FAIL reset_abort_status: got %h want 2", d); end
        repeat (100) @(posedge CLK);
        #2;
        bad = 0;
        for (int i = 0; i < 100; i++) if (cap[cap_base+i] !== 1'b1) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL reset_no_frames: %0d low samples, want 0", bad); end
    endtask

    task automatic test_outside_window;
        logic [31:0] d;
        int bad;
        logic [9:0] oa [3];
        logic [31:0] od [3];
        oa[0] = 10'h100; od[0] = 32'h41;
        oa[1] = 10'h104; od[1] = 32'h08;
        oa[2] = 10'h108; od[2] = 32'h0;
        cap_base = cap_n;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            address = oa[i]; write_data = od[i]; MemWrite = 1'b1; MemRead = 1'b1;
            #1;
            n_cmp++;
            if (hit !== 1'b0) begin n_err++; $display("FAIL outside_hit %h: got %b want 0", oa[i], hit); end
            n_cmp++;
            if (read_data !== 32'h0) begin n_err++; $display("FAIL outside_rdata %h: got %h want 0", oa[i], read_data); end
        end
        @(negedge CLK);
        MemWrite = 1'b0; MemRead = 1'b0;
        bus_read(A_ST, d);
        n_cmp++;
        if (d !== 32'h2) begin n_err++; $display("FAIL outside_status: got %h want 2", d); end
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd434) begin n_err++; $display("FAIL outside_clkdiv: got %0d want 434", d); end
        repeat (10) @(posedge CLK);
        #2;
        bad = 0;
        for (int i = 0; i < 15; i++) if (cap[cap_base+i] !== 1'b1) bad++;
        n_cmp++;
        if (bad !== 0) begin n_err++; $display("FAIL outside_tx_idle: %0d low samples, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_clkdiv();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_mid_reset();
        test_outside_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
